s2_block_copier: RTL and testbench

Fabric-side initiator on the onchip-memory s2 port (6-bit word address, 128-bit data, 16 byte enables). It copies a run of `len` 128-bit words from `src_addr` to `dst_addr` inside the shared HPS/FPGA buffer, XOR-ing each word with a fixed key. It also reports a 32-bit additive checksum of the words read. The block sits beside `soc_system` in the top level, drives the `onchip_memory2_1_s2_*` signals, and is controlled by a start/done handshake from fabric logic (e.g. a PIO-driven mailbox).

---
 rtl/s2_block_copier.sv | 201 ++++++++++++++++++++
 tb/tb_s2_block_copier.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/s2_block_copier.sv
// Copies len words on the onchip-memory s2 port from src_addr to dst_addr,
// XOR-ing each word with a key and summing the 32-bit lanes of every word read.
module s2_block_copier #(
  parameter int                ADDR_W       = 6,
  parameter int                DATA_W       = 128,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] XOR_KEY      = '0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [31:0]           checksum,
  output logic [ADDR_W:0]       words_done,
  output logic [ADDR_W-1:0]     s2_address,
  output logic                  s2_chipselect,
  output logic                  s2_clken,
  output logic                  s2_write,
  input  logic [DATA_W-1:0]     s2_readdata,
  output logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W/8-1:0]   s2_byteenable
);

  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   src_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     idx_reg;
  logic [1:0]          wait_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                aborted_reg;
  logic [31:0]         checksum_reg;
  logic [ADDR_W:0]     words_done_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                cs_reg;
  logic                clken_reg;
  logic                write_reg;
  logic [DATA_W-1:0]   word_reg;

  logic [31:0]         lane [LANES];
  logic [31:0]         lane_sum;
  logic [ADDR_W:0]     idx_next;
  logic                last_wait;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane[gi] = s2_readdata[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + lane[k];
    end
  end

  assign idx_next  = idx_reg + (ADDR_W+1)'(1);
  assign last_wait = (wait_cnt_reg == 2'(READ_LATENCY - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      wait_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      checksum_reg   <= '0;
      words_done_reg <= '0;
      addr_reg       <= '0;
      cs_reg         <= 1'b0;
      clken_reg      <= 1'b0;
      write_reg      <= 1'b0;
      word_reg       <= '0;
    end else begin
      clken_reg <= 1'b1;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          cs_reg    <= 1'b0;
          write_reg <= 1'b0;
          if (start) begin
            checksum_reg   <= '0;
            words_done_reg <= '0;
            aborted_reg    <= 1'b0;
            if (len == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              src_reg   <= src_addr;
              dst_reg   <= dst_addr;
              len_reg   <= len;
              idx_reg   <= '0;
              busy_reg  <= 1'b1;
              addr_reg  <= src_addr;
              cs_reg    <= 1'b1;
              state_reg <= RD;
            end
          end
        end

        RD: begin
          cs_reg       <= 1'b0;
          write_reg    <= 1'b0;
          wait_cnt_reg <= '0;
          if (abort) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (abort) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else if (last_wait) begin
            // The word register doubles as the write-data register.
            word_reg     <= s2_readdata ^ XOR_KEY;
            checksum_reg <= checksum_reg + lane_sum;
            addr_reg     <= dst_reg + idx_reg[ADDR_W-1:0];
            cs_reg       <= 1'b1;
            write_reg    <= 1'b1;
            state_reg    <= WR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end

        WR: begin
          idx_reg        <= idx_next;
          words_done_reg <= words_done_reg + (ADDR_W+1)'(1);
          write_reg      <= 1'b0;
          if (abort || idx_next == len_reg) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            aborted_reg <= abort;
            cs_reg      <= 1'b0;
          end else begin
            addr_reg  <= src_reg + idx_next[ADDR_W-1:0];
            cs_reg    <= 1'b1;
            state_reg <= RD;
          end
        end

        DONE: begin
          cs_reg    <= 1'b0;
          write_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          cs_reg    <= 1'b0;
          write_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign aborted       = aborted_reg;
  assign checksum      = checksum_reg;
  assign words_done    = words_done_reg;
  assign s2_address    = addr_reg;
  assign s2_chipselect = cs_reg;
  assign s2_clken      = clken_reg;
  assign s2_write      = write_reg;
  assign s2_writedata  = word_reg;
  assign s2_byteenable = '1;

endmodule

// File: tb/tb_s2_block_copier.sv
// Two copier instances (latency 1 / key 0, latency 2 / key all-ones) against
// s2 memory models; results compared with a word-by-word forward-copy reference.
module tb_s2_block_copier;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic         start_s   [2];
  logic         abort_s   [2];
  logic [5:0]   src_s     [2];
  logic [5:0]   dst_s     [2];
  logic [6:0]   len_s     [2];
  logic         busy_s    [2];
  logic         done_s    [2];
  logic         aborted_s [2];
  logic [31:0]  cks_s     [2];
  logic [6:0]   wd_s      [2];
  logic [5:0]   addr_s    [2];
  logic         cs_s      [2];
  logic         clken_s   [2];
  logic         wr_s      [2];
  logic [127:0] rdata_s   [2];
  logic [127:0] wdata_s   [2];
  logic [15:0]  be_s      [2];

  s2_block_copier #(.READ_LATENCY(1), .XOR_KEY(128'h0)) dut_a (
    .clk_clk(clk), .reset_reset(srst), .start(start_s[0]), .src_addr(src_s[0]),
    .dst_addr(dst_s[0]), .len(len_s[0]), .abort(abort_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .aborted(aborted_s[0]), .checksum(cks_s[0]), .words_done(wd_s[0]),
    .s2_address(addr_s[0]), .s2_chipselect(cs_s[0]), .s2_clken(clken_s[0]),
    .s2_write(wr_s[0]), .s2_readdata(rdata_s[0]), .s2_writedata(wdata_s[0]),
    .s2_byteenable(be_s[0]));

  s2_block_copier #(.READ_LATENCY(2), .XOR_KEY({128{1'b1}})) dut_b (
    .clk_clk(clk), .reset_reset(srst), .start(start_s[1]), .src_addr(src_s[1]),
    .dst_addr(dst_s[1]), .len(len_s[1]), .abort(abort_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .aborted(aborted_s[1]), .checksum(cks_s[1]), .words_done(wd_s[1]),
    .s2_address(addr_s[1]), .s2_chipselect(cs_s[1]), .s2_clken(clken_s[1]),
    .s2_write(wr_s[1]), .s2_readdata(rdata_s[1]), .s2_writedata(wdata_s[1]),
    .s2_byteenable(be_s[1]));

  // s2 memory models; readdata is random junk except when a read result is due
  logic [127:0] mem      [2][64];
  logic [127:0] init_mem [2][64];
  logic         load_req [2];
  logic [127:0] pd       [2][2];
  logic         pv       [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic [127:0] junk     [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pv[d][0] <= cs_s[d] && clken_s[d] && !wr_s[d];
      pd[d][0] <= mem[d][addr_s[d]];
      pv[d][1] <= pv[d][0];
      pd[d][1] <= pd[d][0];
      junk[d]  <= {$urandom, $urandom, $urandom, $urandom};
      if (load_req[d]) begin
        for (int k = 0; k < 64; k++) mem[d][k] <= init_mem[d][k];
      end else if (cs_s[d] && clken_s[d] && wr_s[d]) begin
        for (int b = 0; b < 16; b++)
          if (be_s[d][b]) mem[d][addr_s[d]][b*8 +: 8] <= wdata_s[d][b*8 +: 8];
      end
    end
  end

  assign rdata_s[0] = pv[0][0] ? pd[0][0] : junk[0];
  assign rdata_s[1] = pv[1][1] ? pd[1][1] : junk[1];

  int errors = 0;
  int checks = 0;
  logic [127:0] ref_mem [64];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int d);
    load_req[d] = 1'b1;
    @(posedge clk); #1;
    load_req[d] = 1'b0;
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check(tag, 256'({busy_s[d], done_s[d], aborted_s[d], cks_s[d], wd_s[d], addr_s[d],
                     cs_s[d], clken_s[d], wr_s[d], wdata_s[d], be_s[d]}),
          256'({3'b000, 32'h0, 7'h0, 6'h0, 3'b000, 128'h0, 16'hFFFF}));
  endtask

  // abort_cyc / restart_cyc: cycle (1 = first RD) in which abort / a stray start is driven; 0 = none
  task automatic run(input int d, input logic [5:0] src, input logic [5:0] dst,
                     input logic [6:0] n, input int abort_cyc, input int restart_cyc,
                     input string tag);
    int lat, per, exp_words, exp_done, cyc, done_cyc, post_cs, bad;
    logic [127:0] key, w;
    logic [31:0] exp_cks;
    lat = d + 1;
    per = 2 + lat;
    key = (d == 1) ? {128{1'b1}} : 128'h0;
    exp_words = (abort_cyc > 0) ? abort_cyc / per : int'(n);
    exp_done  = (abort_cyc > 0) ? abort_cyc + 1 : int'(n) * per + 1;
    for (int k = 0; k < 64; k++) ref_mem[k] = mem[d][k];
    exp_cks = 32'h0;
    for (int i = 0; i < exp_words; i++) begin
      w = ref_mem[(int'(src) + i) % 64];
      exp_cks = exp_cks + w[31:0] + w[63:32] + w[95:64] + w[127:96];
      ref_mem[(int'(dst) + i) % 64] = w ^ key;
    end

    src_s[d] = src; dst_s[d] = dst; len_s[d] = n; start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    cyc = 1; done_cyc = 0; post_cs = 0;
    check($sformatf("%s.busy_c1", tag), 256'(busy_s[d]), 256'(n != 0));
    while (cyc < 500 && done_cyc == 0) begin
      abort_s[d] = (cyc == abort_cyc);
      if (cyc == restart_cyc) begin
        start_s[d] = 1'b1; src_s[d] = src + 6'd7; dst_s[d] = dst + 6'd9; len_s[d] = 7'd1;
      end else begin
        start_s[d] = 1'b0;
      end
      if (cs_s[d] && ((abort_cyc > 0 && cyc > abort_cyc) || n == 0)) post_cs++;
      if (done_s[d]) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    abort_s[d] = 1'b0;
    start_s[d] = 1'b0;
    check($sformatf("%s.done_cycle", tag), 256'(done_cyc), 256'(exp_done));
    check($sformatf("%s.busy_at_done", tag), 256'(busy_s[d]), 256'(0));
    check($sformatf("%s.aborted", tag), 256'(aborted_s[d]), 256'(abort_cyc > 0));
    if (n != 0) check($sformatf("%s.words_done", tag), 256'(wd_s[d]), 256'(exp_words));
    if (n != 0 && abort_cyc == 0) check($sformatf("%s.checksum", tag), 256'(cks_s[d]), 256'(exp_cks));
    if (n == 0 || abort_cyc > 0) check($sformatf("%s.no_access", tag), 256'(post_cs), 256'(0));
    @(posedge clk); #1;
    check($sformatf("%s.done_pulse", tag), 256'({done_s[d], cs_s[d]}), 256'(0));
    bad = 0;
    for (int k = 0; k < 64; k++) if (mem[d][k] !== ref_mem[k]) bad++;
    check($sformatf("%s.mem_words_wrong", tag), 256'(bad), 256'(0));
    $display("run %s dut=%0d src=%0d dst=%0d len=%0d done_cycle=%0d checksum=%0h words=%0d",
             tag, d, src, dst, n, done_cyc, cks_s[d], wd_s[d]);
  endtask

  task automatic preload_pattern(input int d);
    for (int k = 0; k < 64; k++) init_mem[d][k] = {4{32'(k)}};
  endtask

  initial begin
    int cnt;
    srst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; abort_s[d] = 1'b0; load_req[d] = 1'b0;
      src_s[d] = '0; dst_s[d] = '0; len_s[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0, "reset_a");
    check_reset_state(1, "reset_b");
    srst = 1'b0;
    @(posedge clk); #1;
    check("clken_after_reset", 256'({clken_s[0], clken_s[1]}), 256'(2'b11));

    preload_pattern(0); load(0);
    run(0, 6'd0, 6'd16, 7'd4, 0, 0, "basic");
    check("basic.checksum_24", 256'(cks_s[0]), 256'(24));
    run(0, 6'd62, 6'd2, 7'd4, 0, 0, "wrap");
    check("wrap.word5", 256'(mem[0][5]), 256'({4{32'd1}}));
    run(0, 6'd10, 6'd20, 7'd5, 0, 2, "start_busy");
    run(0, 6'd30, 6'd40, 7'd0, 0, 0, "zero_len");
    run(0, 6'd0, 6'd30, 7'd10, 11, 0, "abort");

    // reset in the middle of a run
    src_s[0] = 6'd0; dst_s[0] = 6'd50; len_s[0] = 7'd10; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    check_reset_state(0, "midrun_reset");
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_s[0] || cs_s[0]) cnt++;
    end
    check("midrun_reset.no_done", 256'(cnt), 256'(0));
    $display("midrun reset dut=0 stray_events=%0d", cnt);

    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 64; k++) init_mem[d][k] = {$urandom, $urandom, $urandom, $urandom};
        load(d);
        run(d, 6'($urandom), 6'($urandom), 7'($urandom_range(1, 64)), 0, 0, "random");
      end
    end

    preload_pattern(1); load(1);
    run(1, 6'd0, 6'd16, 7'd4, 0, 0, "basic_lat2");
    check("basic_lat2.checksum_24", 256'(cks_s[1]), 256'(24));
    init_mem[1][5] = 128'h0;
    load(1);
    run(1, 6'd5, 6'd6, 7'd1, 0, 0, "xor_key");
    check("xor_key.word6", 256'(mem[1][6]), 256'({128{1'b1}}));
    check("xor_key.checksum", 256'(cks_s[1]), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
